// File: rtl/button_conditioner_pkg.sv
// Shared constants and helpers for the button/reset conditioner.
package button_conditioner_pkg;

    // 10 ms of debounce at the 25 MHz PLL clock.
    localparam int DEBOUNCE_10MS_25MHZ = 250000;

    // Counter width needed to hold values up to and including 'cycles'.
    function automatic int debounce_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage : button_conditioner_pkg

// File: rtl/button_conditioner_debounce_ch.sv
// One button channel: synchroniser chain, polarity normalisation,
// stability counter, debounced level and one-cycle rise/fall pulses.
module debounce_ch
    import button_conditioner_pkg::*;
#(
    parameter int   SYNC_STAGES_P     = 2,
    parameter int   DEBOUNCE_CYCLES_P = DEBOUNCE_10MS_25MHZ,
    parameter logic IDLE_LEVEL_P      = 1'b0
) (
    input  logic clk_i,
    input  logic reset_n_i,
    input  logic btn_async_unsafe_i,
    output logic btn_o,
    output logic btn_rise_o,
    output logic btn_fall_o
);

    localparam int               CNT_W    = debounce_width(DEBOUNCE_CYCLES_P);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES_P - 1);

    logic [SYNC_STAGES_P-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     btn_q, btn_d;
    logic                     rise_q, rise_d;
    logic                     fall_q, fall_d;
    logic                     sample;

    // Pressed-is-1 view of the synchronised pin.
    assign sample = sync_q[SYNC_STAGES_P-1] ^ IDLE_LEVEL_P;

    // Shift the raw pin into the synchroniser chain.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES_P-2:0], btn_async_unsafe_i};
    end

    // Accept a new level only after it has differed for DEBOUNCE_CYCLES_P
    // consecutive cycles; any return to the current level clears the count.
    always_comb begin
        cnt_d  = cnt_q;
        btn_d  = btn_q;
        rise_d = 1'b0;
        fall_d = 1'b0;
        if (sample == btn_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d  = '0;
            btn_d  = sample;
            rise_d = sample;
            fall_d = ~sample;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State registers; the chain resets to the idle pin level so that no
    // spurious edge is seen when reset is released.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            sync_q <= {SYNC_STAGES_P{IDLE_LEVEL_P}};
            cnt_q  <= '0;
            btn_q  <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            btn_q  <= btn_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign btn_o      = btn_q;
    assign btn_rise_o = rise_q;
    assign btn_fall_o = fall_q;

endmodule : debounce_ch

// File: rtl/button_conditioner.sv
// Reset and button conditioner: produces a clean active-high reset
// (async assert, sync deassert) and NUM_CH_P debounced button channels.
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int                  NUM_CH_P          = 3,
    parameter int                  SYNC_STAGES_P     = 2,
    parameter int                  DEBOUNCE_CYCLES_P = DEBOUNCE_10MS_25MHZ,
    parameter logic [NUM_CH_P-1:0] ACTIVE_LOW_MASK_P = '0
) (
    input  logic                clk_i,
    input  logic                reset_n_i,
    input  logic [NUM_CH_P-1:0] btn_async_unsafe_i,
    output logic                reset_o,
    output logic [NUM_CH_P-1:0] btn_o,
    output logic [NUM_CH_P-1:0] btn_rise_o,
    output logic [NUM_CH_P-1:0] btn_fall_o
);

    logic [SYNC_STAGES_P-1:0] rst_sync_q, rst_sync_d;

    // Zeros shift in once the board reset is released.
    always_comb begin
        rst_sync_d = {rst_sync_q[SYNC_STAGES_P-2:0], 1'b0};
    end

    // Reset synchroniser: set asynchronously, cleared stage by stage.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rst_sync_q <= '1;
        end else begin
            rst_sync_q <= rst_sync_d;
        end
    end

    assign reset_o = rst_sync_q[SYNC_STAGES_P-1];

    // Channels run straight from reset_n_i, independent of reset_o.
    for (genvar i = 0; i < NUM_CH_P; i++) begin : g_ch
        debounce_ch #(
            .SYNC_STAGES_P    (SYNC_STAGES_P),
            .DEBOUNCE_CYCLES_P(DEBOUNCE_CYCLES_P),
            .IDLE_LEVEL_P     (ACTIVE_LOW_MASK_P[i])
        ) u_ch (
            .clk_i             (clk_i),
            .reset_n_i         (reset_n_i),
            .btn_async_unsafe_i(btn_async_unsafe_i[i]),
            .btn_o             (btn_o[i]),
            .btn_rise_o        (btn_rise_o[i]),
            .btn_fall_o        (btn_fall_o[i])
        );
    end

endmodule : button_conditioner

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: NUM_CH_P=3, SYNC_STAGES_P=2,
// DEBOUNCE_CYCLES_P=4, channel 2 active-low.
module tb_button_conditioner;

    localparam int NCH = 3;

    typedef struct {
        logic [NCH-1:0] pin;
        logic [NCH-1:0] btn;
        logic [NCH-1:0] rise;
        logic [NCH-1:0] fall;
    } vec_t;

    typedef struct {
        logic           rst;
        logic [NCH-1:0] btn;
        logic [NCH-1:0] rise;
        logic [NCH-1:0] fall;
    } exp_t;

    logic           clk = 1'b0;
    logic           reset_n = 1'b1;
    logic [NCH-1:0] pins = 3'b100;
    logic           reset_o;
    logic [NCH-1:0] btn_o, btn_rise_o, btn_fall_o;

    int   checks = 0;
    int   failures = 0;
    int   step_no = 0;
    vec_t vecs[$];
    exp_t sb_q[$];

    button_conditioner #(
        .NUM_CH_P         (3),
        .SYNC_STAGES_P    (2),
        .DEBOUNCE_CYCLES_P(4),
        .ACTIVE_LOW_MASK_P(3'b100)
    ) dut (
        .clk_i             (clk),
        .reset_n_i         (reset_n),
        .btn_async_unsafe_i(pins),
        .reset_o           (reset_o),
        .btn_o             (btn_o),
        .btn_rise_o        (btn_rise_o),
        .btn_fall_o        (btn_fall_o)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [NCH-1:0] act, input logic [NCH-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%b required=%b", name, act, req);
        end
    endtask

    task automatic add(input logic [NCH-1:0] p, input logic [NCH-1:0] b,
                       input logic [NCH-1:0] r, input logic [NCH-1:0] f);
        vec_t v;
        v.pin = p; v.btn = b; v.rise = r; v.fall = f;
        vecs.push_back(v);
    endtask

    // Called in the low clock phase: drive pins, expect outputs after next edge.
    task automatic step(input logic [NCH-1:0] p, input logic r_exp,
                        input logic [NCH-1:0] b_exp, input logic [NCH-1:0] ri_exp,
                        input logic [NCH-1:0] f_exp);
        exp_t e;
        pins = p;
        e.rst = r_exp; e.btn = b_exp; e.rise = ri_exp; e.fall = f_exp;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        step_no++;
        if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_empty actual=0 required=1");
        end else begin
            e = sb_q.pop_front();
            check($sformatf("s%0d_reset_o", step_no), {2'b00, reset_o}, {2'b00, e.rst});
            check($sformatf("s%0d_btn_o", step_no), btn_o, e.btn);
            check($sformatf("s%0d_rise", step_no), btn_rise_o, e.rise);
            check($sformatf("s%0d_fall", step_no), btn_fall_o, e.fall);
        end
        @(negedge clk);
    endtask

    task automatic check_in_reset(input string tag);
        check({tag, "_reset_o"}, {2'b00, reset_o}, 3'b001);
        check({tag, "_btn_o"}, btn_o, 3'b000);
        check({tag, "_rise"}, btn_rise_o, 3'b000);
        check({tag, "_fall"}, btn_fall_o, 3'b000);
    endtask

    initial begin
        // Clean press/release on ch0.
        for (int i = 0; i < 5; i++) add(3'b101, 3'b000, 3'b000, 3'b000);
        add(3'b101, 3'b001, 3'b001, 3'b000);
        add(3'b101, 3'b001, 3'b000, 3'b000);
        for (int i = 0; i < 5; i++) add(3'b100, 3'b001, 3'b000, 3'b000);
        add(3'b100, 3'b000, 3'b000, 3'b001);
        add(3'b100, 3'b000, 3'b000, 3'b000);
        // Glitch on ch1: 3 cycles high is rejected.
        for (int i = 0; i < 3; i++) add(3'b110, 3'b000, 3'b000, 3'b000);
        for (int i = 0; i < 5; i++) add(3'b100, 3'b000, 3'b000, 3'b000);
        // 4-cycle hold on ch1 is accepted, then released.
        for (int i = 0; i < 4; i++) add(3'b110, 3'b000, 3'b000, 3'b000);
        add(3'b100, 3'b000, 3'b000, 3'b000);
        add(3'b100, 3'b010, 3'b010, 3'b000);
        for (int i = 0; i < 3; i++) add(3'b100, 3'b010, 3'b000, 3'b000);
        add(3'b100, 3'b000, 3'b000, 3'b010);
        add(3'b100, 3'b000, 3'b000, 3'b000);
        // Active-low ch2: pin driven low is a press.
        for (int i = 0; i < 5; i++) add(3'b000, 3'b000, 3'b000, 3'b000);
        add(3'b000, 3'b100, 3'b100, 3'b000);
        add(3'b000, 3'b100, 3'b000, 3'b000);
        for (int i = 0; i < 5; i++) add(3'b100, 3'b100, 3'b000, 3'b000);
        add(3'b100, 3'b000, 3'b000, 3'b100);
        add(3'b100, 3'b000, 3'b000, 3'b000);
        // Simultaneous ch0+ch1 press, held.
        for (int i = 0; i < 5; i++) add(3'b111, 3'b000, 3'b000, 3'b000);
        add(3'b111, 3'b011, 3'b011, 3'b000);
        add(3'b111, 3'b011, 3'b000, 3'b000);

        // Reset asserted mid-cycle, ch2 pin held at its idle level 1.
        #2 reset_n = 1'b0;
        #1 check_in_reset("por_immediate");
        repeat (2) @(posedge clk);
        #1 check_in_reset("por_held");
        @(negedge clk);
        reset_n = 1'b1;
        step(3'b100, 1'b1, 3'b000, 3'b000, 3'b000);
        step(3'b100, 1'b0, 3'b000, 3'b000, 3'b000);
        step(3'b100, 1'b0, 3'b000, 3'b000, 3'b000);

        foreach (vecs[i]) step(vecs[i].pin, 1'b0, vecs[i].btn, vecs[i].rise, vecs[i].fall);

        // Asynchronous reset while ch0/ch1 are reported pressed.
        pins = 3'b100;
        #1 reset_n = 1'b0;
        #1 check_in_reset("async_pressed");
        #1 reset_n = 1'b1;
        step(3'b100, 1'b1, 3'b000, 3'b000, 3'b000);
        step(3'b100, 1'b0, 3'b000, 3'b000, 3'b000);
        step(3'b100, 1'b0, 3'b000, 3'b000, 3'b000);

        // Reset pulse while ch0 is counting (count 2).
        for (int i = 0; i < 4; i++) step(3'b101, 1'b0, 3'b000, 3'b000, 3'b000);
        #1 reset_n = 1'b0;
        #1 check_in_reset("midcount");
        #1 reset_n = 1'b1;
        step(3'b101, 1'b1, 3'b000, 3'b000, 3'b000);
        for (int i = 0; i < 4; i++) step(3'b101, 1'b0, 3'b000, 3'b000, 3'b000);
        step(3'b101, 1'b0, 3'b001, 3'b001, 3'b000);
        step(3'b101, 1'b0, 3'b001, 3'b000, 3'b000);
        for (int i = 0; i < 5; i++) step(3'b100, 1'b0, 3'b001, 3'b000, 3'b000);
        step(3'b100, 1'b0, 3'b000, 3'b000, 3'b001);
        step(3'b100, 1'b0, 3'b000, 3'b000, 3'b000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_button_conditioner
